// File: rtl/doodle_pkg.sv
// Shared types, state encodings and default geometry for the doodle motion controller,
// renderer and platform generator.
package doodle_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_w_t;  // one guard bit for wrap/overflow compares
  typedef logic [3:0]         state_t;

  // One-hot {DONE,DOWN,UP,I}
  localparam state_t ST_I    = 4'b0001;
  localparam state_t ST_UP   = 4'b0010;
  localparam state_t ST_DOWN = 4'b0100;
  localparam state_t ST_DONE = 4'b1000;

  localparam int DEF_H_RES       = 640;
  localparam int DEF_V_RES       = 480;
  localparam int DEF_N_PLAT      = 4;
  localparam int DEF_JUMP_HEIGHT = 120;
  localparam int DEF_V_STEP      = 4;
  localparam int DEF_H_STEP      = 4;
  localparam int DEF_DOODLE_W    = 32;
  localparam int DEF_DOODLE_H    = 32;
  localparam int DEF_PLAT_W      = 64;
  localparam int DEF_SCROLL_LINE = 160;
  localparam int DEF_START_X     = 304;
  localparam int DEF_START_Y     = 400;
  localparam int DEF_SCORE_W     = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/doodle_plat_hit.sv
// Landing detector: per-platform crossing/overlap test for one falling step,
// followed by a lowest-index-wins priority encoder.
module doodle_plat_hit
  import doodle_pkg::*;
#(
  parameter int N_PLAT   = DEF_N_PLAT,
  parameter int V_STEP   = DEF_V_STEP,
  parameter int DOODLE_W = DEF_DOODLE_W,
  parameter int DOODLE_H = DEF_DOODLE_H,
  parameter int PLAT_W   = DEF_PLAT_W
) (
  input  logic [COORD_W-1:0]        doodle_x,
  input  logic [COORD_W-1:0]        doodle_y,
  input  logic [N_PLAT*COORD_W-1:0] plat_x,
  input  logic [N_PLAT*COORD_W-1:0] plat_y,
  output logic                      hit,
  output logic [idx_w(N_PLAT)-1:0]  hit_idx
);

  localparam int IDX_W = idx_w(N_PLAT);

  coord_w_t old_bot, new_bot, left_edge, right_edge;
  logic [N_PLAT-1:0] cand;

  assign left_edge  = {1'b0, doodle_x};
  assign right_edge = left_edge + coord_w_t'(DOODLE_W);
  assign old_bot    = {1'b0, doodle_y} + coord_w_t'(DOODLE_H);
  assign new_bot    = old_bot + coord_w_t'(V_STEP);

  for (genvar gi = 0; gi < N_PLAT; gi++) begin : g_plat
    coord_w_t px, py;
    assign px = {1'b0, plat_x[gi*COORD_W +: COORD_W]};
    assign py = {1'b0, plat_y[gi*COORD_W +: COORD_W]};
    // Bottom edge must cross the platform top during this step, with horizontal overlap
    assign cand[gi] = (old_bot < py) && (new_bot >= py) &&
                      (right_edge > px) && (left_edge < px + coord_w_t'(PLAT_W));
  end

  always_comb begin
    hit     = |cand;
    hit_idx = '0;
    for (int i = N_PLAT - 1; i >= 0; i--) begin
      if (cand[i]) hit_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/doodle_jump_ctrl.sv
// Doodle motion controller: per-tick jump/fall FSM, horizontal wrap-around motion,
// platform landing, world scrolling and saturating score.
module doodle_jump_ctrl
  import doodle_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int N_PLAT      = DEF_N_PLAT,
  parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
  parameter int V_STEP      = DEF_V_STEP,
  parameter int H_STEP      = DEF_H_STEP,
  parameter int DOODLE_W    = DEF_DOODLE_W,
  parameter int DOODLE_H    = DEF_DOODLE_H,
  parameter int PLAT_W      = DEF_PLAT_W,
  parameter int SCROLL_LINE = DEF_SCROLL_LINE,
  parameter int START_X     = DEF_START_X,
  parameter int START_Y     = DEF_START_Y,
  parameter int SCORE_W     = DEF_SCORE_W
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Ack,
  input  logic                      tick,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic [N_PLAT*COORD_W-1:0] plat_x,
  input  logic [N_PLAT*COORD_W-1:0] plat_y,
  output logic [COORD_W-1:0]        doodle_x,
  output logic [COORD_W-1:0]        doodle_y,
  output logic                      scroll_valid,
  output logic [COORD_W-1:0]        scroll_px,
  output logic                      land_pulse,
  output logic [idx_w(N_PLAT)-1:0]  land_idx,
  output logic [SCORE_W-1:0]        score,
  output logic                      q_I,
  output logic                      q_Up,
  output logic                      q_Down,
  output logic                      q_Done
);

  localparam int IDX_W  = idx_w(N_PLAT);
  localparam int RISE_W = $clog2(JUMP_HEIGHT + V_STEP + 1);
  localparam int SW1    = SCORE_W + 1;

  localparam coord_t   START_X_C  = coord_t'(START_X);
  localparam coord_t   START_Y_C  = coord_t'(START_Y);
  localparam coord_t   V_STEP_C   = coord_t'(V_STEP);
  localparam coord_t   DOODLE_H_C = coord_t'(DOODLE_H);
  localparam coord_w_t H_RES_W    = coord_w_t'(H_RES);
  localparam coord_w_t H_STEP_W   = coord_w_t'(H_STEP);
  localparam coord_w_t V_RES_W    = coord_w_t'(V_RES);
  localparam coord_w_t V_STEP_W   = coord_w_t'(V_STEP);
  localparam coord_w_t SCROLL_LIM = coord_w_t'(SCROLL_LINE + V_STEP);
  localparam logic [RISE_W-1:0] RISE_STEP = RISE_W'(V_STEP);
  localparam logic [RISE_W-1:0] RISE_TOP  = RISE_W'(JUMP_HEIGHT);
  localparam logic [SW1-1:0]    SCORE_STEP = SW1'(V_STEP);

  state_t            state_q, state_d;
  coord_t            x_q, x_d, y_q, y_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [RISE_W-1:0] rise_q, rise_d;
  logic              scroll_q, scroll_d;
  logic              land_q, land_d;
  logic [IDX_W-1:0]  land_idx_q, land_idx_d;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  coord_t            x_mv;
  coord_w_t          xw, new_y;
  logic [SW1-1:0]    score_sum;

  doodle_plat_hit #(
    .N_PLAT  (N_PLAT),
    .V_STEP  (V_STEP),
    .DOODLE_W(DOODLE_W),
    .DOODLE_H(DOODLE_H),
    .PLAT_W  (PLAT_W)
  ) u_plat_hit (
    .doodle_x(x_q),
    .doodle_y(y_q),
    .plat_x  (plat_x),
    .plat_y  (plat_y),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  // Horizontal step with wrap; opposing buttons cancel
  always_comb begin
    xw   = {1'b0, x_q};
    x_mv = x_q;
    if (btn_left && !btn_right) begin
      x_mv = (xw < H_STEP_W) ? coord_t'(xw + H_RES_W - H_STEP_W) : coord_t'(xw - H_STEP_W);
    end else if (btn_right && !btn_left) begin
      x_mv = (xw + H_STEP_W >= H_RES_W) ? coord_t'(xw + H_STEP_W - H_RES_W)
                                        : coord_t'(xw + H_STEP_W);
    end
  end

  assign new_y     = {1'b0, y_q} + V_STEP_W;
  assign score_sum = {1'b0, score_q} + SCORE_STEP;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    score_d    = score_q;
    rise_d     = rise_q;
    scroll_d   = 1'b0;
    land_d     = 1'b0;
    land_idx_d = land_idx_q;
    case (state_q)
      ST_I: begin
        x_d = START_X_C;
        y_d = START_Y_C;
        if (Start) begin
          state_d = ST_UP;
          rise_d  = '0;
          score_d = '0;
        end
      end
      ST_UP: begin
        if (tick) begin
          x_d    = x_mv;
          rise_d = rise_q + RISE_STEP;
          // Above the scroll line the world moves instead of the doodle
          if ({1'b0, y_q} < SCROLL_LIM) begin
            scroll_d = 1'b1;
            score_d  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          end else begin
            y_d = y_q - V_STEP_C;
          end
          if (rise_d >= RISE_TOP) state_d = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (tick) begin
          x_d = x_mv;
          if (hit) begin
            y_d        = plat_y[int'(hit_idx)*COORD_W +: COORD_W] - DOODLE_H_C;
            rise_d     = '0;
            land_d     = 1'b1;
            land_idx_d = hit_idx;
            state_d    = ST_UP;
          end else if (new_y >= V_RES_W) begin
            state_d = ST_DONE;
          end else begin
            y_d = new_y[COORD_W-1:0];
          end
        end
      end
      ST_DONE: begin
        if (Ack) begin
          state_d = ST_I;
          x_d     = START_X_C;
          y_d     = START_Y_C;
        end
      end
      default: state_d = ST_I;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_I;
      x_q        <= START_X_C;
      y_q        <= START_Y_C;
      score_q    <= '0;
      rise_q     <= '0;
      scroll_q   <= 1'b0;
      land_q     <= 1'b0;
      land_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      score_q    <= score_d;
      rise_q     <= rise_d;
      scroll_q   <= scroll_d;
      land_q     <= land_d;
      land_idx_q <= land_idx_d;
    end
  end

  assign doodle_x     = x_q;
  assign doodle_y     = y_q;
  assign scroll_valid = scroll_q;
  assign scroll_px    = scroll_q ? V_STEP_C : '0;
  assign land_pulse   = land_q;
  assign land_idx     = land_idx_q;
  assign score        = score_q;
  assign q_I          = state_q[0];
  assign q_Up         = state_q[1];
  assign q_Down       = state_q[2];
  assign q_Done       = state_q[3];

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
// Directed bench for doodle_jump_ctrl: a default-geometry instance plus a START_Y=200
// instance sharing the same stimulus to exercise scrolling.
module tb_doodle_jump_ctrl;

  logic Clk = 1'b0;
  logic Reset, Start, Ack, tick, btn_left, btn_right;
  logic [39:0] plat_x, plat_y;
  logic [9:0] px_arr [4];
  logic [9:0] py_arr [4];

  logic [9:0] doodle_x, doodle_y, scroll_px;
  logic       scroll_valid, land_pulse, q_I, q_Up, q_Down, q_Done;
  logic [1:0] land_idx;
  logic [15:0] score;

  logic [9:0] doodle_x2, doodle_y2, scroll_px2;
  logic       scroll_valid2, land_pulse2, q_I2, q_Up2, q_Down2, q_Done2;
  logic [1:0] land_idx2;
  logic [15:0] score2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign plat_x[gi*10 +: 10] = px_arr[gi];
    assign plat_y[gi*10 +: 10] = py_arr[gi];
  end

  doodle_jump_ctrl u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .plat_x(plat_x), .plat_y(plat_y),
    .doodle_x(doodle_x), .doodle_y(doodle_y), .scroll_valid(scroll_valid),
    .scroll_px(scroll_px), .land_pulse(land_pulse), .land_idx(land_idx), .score(score),
    .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done)
  );

  doodle_jump_ctrl #(.START_Y(200)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .plat_x(plat_x), .plat_y(plat_y),
    .doodle_x(doodle_x2), .doodle_y(doodle_y2), .scroll_valid(scroll_valid2),
    .scroll_px(scroll_px2), .land_pulse(land_pulse2), .land_idx(land_idx2), .score(score2),
    .q_I(q_I2), .q_Up(q_Up2), .q_Down(q_Down2), .q_Done(q_Done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_far();
    for (int i = 0; i < 4; i++) begin
      px_arr[i] = 10'd300;
      py_arr[i] = 10'd1000;
    end
  endtask

  task automatic do_tick();
    @(negedge Clk);
    tick = 1'b1;
    @(posedge Clk);
    #1;
    tick = 1'b0;
    $display("tick: x=%0d y=%0d st=%b%b%b%b land=%0b/%0d scr=%0b score=%0d | y2=%0d scr2=%0b score2=%0d",
             doodle_x, doodle_y, q_Done, q_Down, q_Up, q_I, land_pulse, land_idx,
             scroll_valid, score, doodle_y2, scroll_valid2, score2);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic idle_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    $display("start: x=%0d y=%0d st=%b%b%b%b", doodle_x, doodle_y, q_Done, q_Down, q_Up, q_I);
  endtask

  task automatic pulse_ack();
    @(negedge Clk);
    Ack = 1'b1;
    @(posedge Clk);
    #1;
    Ack = 1'b0;
    $display("ack: x=%0d y=%0d st=%b%b%b%b", doodle_x, doodle_y, q_Done, q_Down, q_Up, q_I);
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    $display("reset pulse");
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0;
    set_far();
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_x", doodle_x, 304);
    check_eq("rst_y", doodle_y, 400);
    check_eq("rst_qI", q_I, 1);
    check_eq("rst_score", score, 0);
    check_eq("rst_scroll", scroll_valid, 0);
    check_eq("rst_scroll_px", scroll_px, 0);
    check_eq("rst_land", land_pulse, 0);
    check_eq("rst_land_idx", land_idx, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Ticks in I do nothing
    do_tick();
    check_eq("idle_I_y", doodle_y, 400);
    check_eq("idle_I_q", q_I, 1);
    pulse_start();
    check_eq("start_qUp", q_Up, 1);
    check_eq("start_y", doodle_y, 400);

    // Rise 30 ticks; second instance scrolls after reaching the scroll line
    for (int k = 1; k <= 30; k++) begin
      do_tick();
      check_eq("t1_noscroll", scroll_valid, 0);
      check_eq("t3_scroll", scroll_valid2, (k > 10) ? 1 : 0);
      check_eq("t3_scroll_px", scroll_px2, (k > 10) ? 4 : 0);
      if (k == 10) check_eq("t3_y10", doodle_y2, 160);
    end
    check_eq("t1_y", doodle_y, 280);
    check_eq("t1_qDown", q_Down, 1);
    check_eq("t1_score", score, 0);
    check_eq("t3_y", doodle_y2, 160);
    check_eq("t3_score", score2, 80);
    check_eq("t3_qDown", q_Down2, 1);
    idle_cycle();
    check_eq("t3_scroll_clr", scroll_valid2, 0);
    check_eq("t3_scroll_px_clr", scroll_px2, 0);

    // Landing on platform 2 at (300,350)
    py_arr[2] = 10'd350;
    do_ticks(9);
    check_eq("t2_noland", land_pulse, 0);
    check_eq("t2_y9", doodle_y, 316);
    do_tick();
    check_eq("t2_land", land_pulse, 1);
    check_eq("t2_idx", land_idx, 2);
    check_eq("t2_y", doodle_y, 318);
    check_eq("t2_qUp", q_Up, 1);
    idle_cycle();
    check_eq("t2_land_clr", land_pulse, 0);
    check_eq("t2_y_hold", doodle_y, 318);
    // A full bounce from a fresh rise counter
    do_ticks(29);
    check_eq("t2_rise29_q", q_Up, 1);
    check_eq("t2_rise29_y", doodle_y, 202);
    do_tick();
    check_eq("t2_rise30_q", q_Down, 1);
    check_eq("t2_rise30_y", doodle_y, 198);

    // Fall off the bottom
    pulse_reset();
    set_far();
    pulse_start();
    do_ticks(30);
    do_ticks(49);
    check_eq("t4_y476", doodle_y, 476);
    check_eq("t4_still_down", q_Down, 1);
    do_tick();
    check_eq("t4_done", q_Done, 1);
    check_eq("t4_y_frozen", doodle_y, 476);
    do_tick();
    check_eq("t4_done_hold", q_Done, 1);
    check_eq("t4_y_hold", doodle_y, 476);
    pulse_ack();
    check_eq("t4_ack_qI", q_I, 1);
    check_eq("t4_ack_x", doodle_x, 304);
    check_eq("t4_ack_y", doodle_y, 400);
    // Second instance reaches DONE with score 80; Ack keeps score until Start
    do_ticks(29);
    check_eq("t4b_I_x", doodle_x, 304);
    check_eq("t4b_done2", q_Done2, 1);
    check_eq("t4b_y2", doodle_y2, 476);
    pulse_ack();
    check_eq("t4b_ack_qI2", q_I2, 1);
    check_eq("t4b_ack_y2", doodle_y2, 200);
    check_eq("t4b_score_held", score2, 80);

    // Horizontal motion and wrap
    pulse_start();
    check_eq("t5_score_clr", score2, 0);
    btn_left = 1'b1; btn_right = 1'b1;
    do_tick();
    check_eq("t5_both", doodle_x, 304);
    btn_right = 1'b0;
    do_ticks(76);
    check_eq("t5_left76", doodle_x, 0);
    do_tick();
    check_eq("t5_wrap_left", doodle_x, 636);
    btn_left = 1'b0; btn_right = 1'b1;
    do_tick();
    check_eq("t5_wrap_right", doodle_x, 0);
    check_eq("t5_still_down", q_Down, 1);
    btn_right = 1'b0;

    // Priority between simultaneous hits, ignored Start, async abort
    pulse_reset();
    set_far();
    py_arr[0] = 10'd350;
    py_arr[1] = 10'd350;
    pulse_start();
    do_ticks(5);
    check_eq("t6_y5", doodle_y, 380);
    pulse_start();
    check_eq("t6_start_ign_q", q_Up, 1);
    check_eq("t6_start_ign_y", doodle_y, 380);
    do_ticks(25);
    check_eq("t6_qDown", q_Down, 1);
    do_ticks(9);
    do_tick();
    check_eq("t6_land", land_pulse, 1);
    check_eq("t6_idx", land_idx, 0);
    check_eq("t6_y", doodle_y, 318);
    Reset = 1'b1;
    #1;
    check_eq("t6_arst_qI", q_I, 1);
    check_eq("t6_arst_x", doodle_x, 304);
    check_eq("t6_arst_y", doodle_y, 400);
    check_eq("t6_arst_land", land_pulse, 0);
    check_eq("t6_arst_idx", land_idx, 0);
    check_eq("t6_arst_score2", score2, 0);
    check_eq("t6_arst_scroll2", scroll_valid2, 0);
    check_eq("t6_arst_y2", doodle_y2, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/doodle_jump_ctrl.md
Name: doodle_jump_ctrl

Overview:
Parametrised doodle motion controller. It runs the jump/fall state machine on a per-frame tick and moves the doodle horizontally with edge wrap-around. It detects landings against N_PLAT platforms, scrolls the world when the doodle climbs past a scroll line, and accumulates score from scrolled height. It sits between the input debouncers/platform generator and the VGA renderer, and replaces the fixed-height, hard-coded-platform jump FSM.

Parameters:
H_RES, 640, screen width in pixels
V_RES, 480, screen height in pixels
N_PLAT, 4, number of platforms checked per tick
JUMP_HEIGHT, 120, pixels risen per bounce before falling
V_STEP, 4, vertical pixels moved per tick
H_STEP, 4, horizontal pixels moved per tick
DOODLE_W, 32, doodle width in pixels
DOODLE_H, 32, doodle height in pixels
PLAT_W, 64, platform width in pixels
SCROLL_LINE, 160, minimum doodle_y; the world scrolls while rising above it
START_X, 304, doodle_x after reset/Start
START_Y, 400, doodle_y after reset/Start
SCORE_W, 16, score width

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  begin game (sampled in I only)
Ack  in  1  acknowledge game over (sampled in DONE only)
tick  in  1  one-cycle frame strobe; all motion happens only on tick cycles
btn_left  in  1  move left request
btn_right  in  1  move right request
plat_x  in  N_PLAT*10  packed platform left edges, platform i at [10*i+9:10*i]
plat_y  in  N_PLAT*10  packed platform top edges, same packing
doodle_x  out  10  doodle left edge
doodle_y  out  10  doodle top edge
scroll_valid  out  1  one-cycle pulse: world scrolls down by scroll_px this tick
scroll_px  out  10  scroll amount (V_STEP when valid, else 0)
land_pulse  out  1  one-cycle pulse on landing
land_idx  out  $clog2(N_PLAT) (min 1)  index of the platform landed on
score  out  SCORE_W  accumulated scrolled height, saturating
q_I, q_Up, q_Down, q_Done  out  1 each  one-hot state flags

Behaviour:
- Reset (async, Reset high): state I; doodle_x=START_X, doodle_y=START_Y, score=0, rise_cnt=0, scroll_valid=0, scroll_px=0, land_pulse=0, land_idx=0.
- State encoding is one-hot {DONE,DOWN,UP,I}. Illegal encodings go to I on the next Clk.
- I: holds start position. When Start=1 (not tick-gated), on the next Clk: UP, rise_cnt=0, score=0, position set to START_X/START_Y.
- UP, on tick:
  - rise_cnt += V_STEP.
  - If doodle_y - V_STEP < SCROLL_LINE: doodle_y holds, scroll_valid=1, scroll_px=V_STEP, score += V_STEP (saturating at all-ones).
  - Else doodle_y -= V_STEP.
  - If the new rise_cnt >= JUMP_HEIGHT: DOWN.
- DOWN, on tick: new_y = doodle_y + V_STEP, computed 11-bit.
  - Landing on platform i requires both: old bottom (doodle_y+DOODLE_H) < plat_y[i] and new bottom >= plat_y[i]; and doodle_x+DOODLE_W > plat_x[i] and doodle_x < plat_x[i]+PLAT_W (11-bit compares).
  - On landing: lowest-index hit wins; doodle_y = plat_y[i]-DOODLE_H, rise_cnt=0, land_pulse=1, land_idx=i, state UP.
  - Else if new_y >= V_RES: DONE, doodle_y frozen at its previous value. Landing takes priority over game-over in the same tick.
  - Else doodle_y = new_y.
- DONE: position and score frozen. Ack=1 leads to I on the next Clk with start position restored; score is held until the next Start.
- Horizontal (UP/DOWN, on tick):
  - left only: x<H_STEP gives x+H_RES-H_STEP, else x-H_STEP.
  - right only: x+H_STEP>=H_RES gives x+H_STEP-H_RES, else x+H_STEP.
  - both or neither: no move.
  - Collision uses the pre-move x.
- Pulses (scroll_valid, land_pulse) last exactly one Clk. scroll_px returns to 0 with scroll_valid.
- Non-tick cycles: no motion, no pulses.
- Start outside I and Ack outside DONE are ignored. Reset mid-operation aborts immediately to reset values.

Decomposition:
- Package doodle_pkg holds:
  - state localparams ST_I/ST_UP/ST_DOWN/ST_DONE
  - COORD_W=10
  - default geometry constants shared with the renderer and platform generator
- Sub-module doodle_plat_hit (combinational): N_PLAT-wide crossing/overlap compare plus lowest-index priority encoder, outputs hit and hit_idx.

Test Plan:
1. Reset, then Start, then 30 ticks with no platforms in range (all plat_y=1000) -> y=280, q_Down=1 after the 30th tick, score=0, no scroll_valid.
2. From test 1, platform 2 at (300,350) -> 10 fall ticks, land_pulse with land_idx=2, y=318, state UP, rise_cnt=0.
3. START_Y=200, 30 rise ticks -> first 10 ticks y reaches 160; next 20 ticks scroll_valid each with scroll_px=4; score=80, y=160; state DOWN.
4. Fall with no platforms from y=280 -> DONE on the tick where new_y>=480 (y frozen at 476); Ack -> I, x=304, y=400.
5. Hold btn_left 76 ticks -> x=0; one more tick -> x=636; btn_right one tick -> x=0; both buttons -> x unchanged.
6. Platforms 0 and 1 both at (300,350) -> land_idx=0. Reset asserted mid-UP -> all outputs at reset values the same cycle; Start pulse while in UP -> no effect.
